// File: rtl/prbs4_if.sv
// PRBS4 checker bus: receive word stream in, lock/error status out.
interface prbs4_if #(
    parameter int ERR_W = 16
);
    logic             in_valid;
    logic [3:0]       in_data;
    logic             clear_err;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic             zero_det;

    // Stream source / status consumer side
    modport master (
        output in_valid, in_data, clear_err,
        input  locked, err_pulse, err_count, zero_det
    );

    // Checker side
    modport slave (
        input  in_valid, in_data, clear_err,
        output locked, err_pulse, err_count, zero_det
    );
endinterface

// File: rtl/prbs4_checker.sv
// prbs4_checker: hunts for alignment to the 4-bit PRBS stream
// (next word = {w[2:0], w[1]^w[3]}), locks, then counts word errors
// against a free-running local replica. Drops lock after LOSS_CNT
// consecutive mismatches.
// Optional macro PRBS4_CHK_ZERO_DET_EN: sticky all-zero word detector;
// a zero word in HUNT also discards the current seed and run.
module prbs4_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic   clk,
    input  logic   rst,
    prbs4_if.slave bus
);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);

    typedef enum logic [0:0] {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_t;

    function automatic logic [3:0] prbs_next(input logic [3:0] w);
        return {w[2:0], w[1] ^ w[3]};
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         prev_q, prev_d;
    logic               prev_ok_q, prev_ok_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [3:0]         exp_q, exp_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic               zero_word;
    logic [RUN_W-1:0]   run_inc;
    logic [MISS_W-1:0]  miss_inc;

    assign run_inc  = run_q + RUN_W'(1);
    assign miss_inc = miss_q + MISS_W'(1);

`ifdef PRBS4_CHK_ZERO_DET_EN
    logic zero_det_q, zero_det_d;
    assign zero_word    = bus.in_valid && (bus.in_data == 4'h0);
    assign bus.zero_det = zero_det_q;
`else
    assign zero_word    = 1'b0;
    assign bus.zero_det = 1'b0;
`endif

    assign bus.locked    = (state_q == ST_LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;

    // State and status registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            prev_q      <= '0;
            prev_ok_q   <= 1'b0;
            run_q       <= '0;
            exp_q       <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
`ifdef PRBS4_CHK_ZERO_DET_EN
            zero_det_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            prev_ok_q   <= prev_ok_d;
            run_q       <= run_d;
            exp_q       <= exp_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
`ifdef PRBS4_CHK_ZERO_DET_EN
            zero_det_q  <= zero_det_d;
`endif
        end
    end

    // Hunt/lock next-state, replica advance and error accounting
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        prev_ok_d   = prev_ok_q;
        run_d       = run_q;
        exp_d       = exp_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
`ifdef PRBS4_CHK_ZERO_DET_EN
        zero_det_d  = zero_det_q | zero_word;
`endif
        if (bus.in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (zero_word) begin
                        // all-zero is the generator lockup value, never a seed
                        run_d     = '0;
                        prev_ok_d = 1'b0;
                    end else if (!prev_ok_q) begin
                        prev_d    = bus.in_data;
                        prev_ok_d = 1'b1;
                    end else begin
                        prev_d = bus.in_data;
                        if (bus.in_data == prbs_next(prev_q)) begin
                            if (run_inc == RUN_W'(LOCK_CNT)) begin
                                state_d = ST_LOCKED;
                                exp_d   = prbs_next(bus.in_data);
                                miss_d  = '0;
                                run_d   = '0;
                            end else begin
                                run_d = run_inc;
                            end
                        end else begin
                            run_d = '0;
                        end
                    end
                end
                default: begin
                    // replica free-runs so one bad word costs one error
                    exp_d = prbs_next(exp_q);
                    if (bus.in_data == exp_q) begin
                        miss_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != {ERR_W{1'b1}})
                            err_count_d = err_count_q + ERR_W'(1);
                        if (miss_inc == MISS_W'(LOSS_CNT)) begin
                            state_d   = ST_HUNT;
                            run_d     = '0;
                            prev_d    = bus.in_data;
                            prev_ok_d = 1'b1;
                            miss_d    = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
            endcase
        end
        // clear wins over a concurrent increment
        if (bus.clear_err) begin
            err_count_d = '0;
`ifdef PRBS4_CHK_ZERO_DET_EN
            zero_det_d  = 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_prbs4_checker.sv
// Directed bench for prbs4_checker: a vector table on a default-config
// instance plus hand sequences on a small-counter instance.
module tb_prbs4_checker;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    prbs4_if #(.ERR_W(16)) bus_a();
    prbs4_if #(.ERR_W(2))  bus_b();

    prbs4_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a)
    );
    prbs4_checker #(.LOCK_CNT(4), .LOSS_CNT(8), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [3:0]  data;
        logic        clr;
        logic        lk;
        logic        pl;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [3:0] d, input logic c,
                       input logic lk, input logic pl, input logic [15:0] cnt);
        vec_t e;
        e.rst = r; e.vld = v; e.data = d; e.clr = c;
        e.lk = lk; e.pl = pl; e.cnt = cnt;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step_b(input logic r, input logic v, input logic [3:0] d, input logic c);
        @(negedge clk);
        rst_b = r; bus_b.in_valid = v; bus_b.in_data = d; bus_b.clear_err = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.clear_err = 1'b0;
        rst_b = 1'b1; bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.clear_err = 1'b0;

        // rst  vld data clr  locked pulse count
        add(1, 0, 4'h0, 0, 0, 0, 0);   // reset state
        add(0, 1, 4'hE, 0, 0, 0, 0);   // seed
        add(0, 1, 4'hC, 0, 0, 0, 0);
        add(0, 1, 4'h9, 0, 0, 0, 0);
        add(0, 1, 4'h3, 0, 0, 0, 0);
        add(0, 1, 4'h7, 0, 1, 0, 0);   // 4th match -> lock
        add(0, 1, 4'hF, 0, 1, 0, 0);
        add(0, 1, 4'hE, 0, 1, 0, 0);
        add(0, 1, 4'hC, 0, 1, 0, 0);
        add(0, 1, 4'h8, 0, 1, 1, 1);   // corrupted 9
        add(0, 1, 4'h3, 0, 1, 0, 1);
        add(0, 1, 4'h7, 0, 1, 0, 1);
        add(0, 1, 4'hA, 0, 1, 1, 2);   // loss sequence
        add(0, 1, 4'hA, 0, 1, 1, 3);
        add(0, 1, 4'hA, 0, 0, 1, 4);   // 3rd miss -> hunt, error counted
        add(0, 1, 4'hE, 0, 0, 0, 4);
        add(0, 1, 4'hC, 0, 0, 0, 4);
        add(0, 1, 4'h9, 0, 0, 0, 4);
        add(0, 1, 4'h3, 0, 0, 0, 4);
        add(0, 1, 4'h7, 0, 1, 0, 4);   // relock
        add(0, 0, 4'h5, 0, 1, 0, 4);   // idle ignored
        add(0, 1, 4'hF, 0, 1, 0, 4);
        add(0, 0, 4'h0, 1, 1, 0, 0);   // clear
        add(0, 1, 4'h5, 1, 1, 1, 0);   // clear beats concurrent error
        add(1, 1, 4'hC, 0, 0, 0, 0);   // rst mid-lock
        add(0, 1, 4'hE, 0, 0, 0, 0);   // gaps / hunt reset
        add(0, 1, 4'hC, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 4'h0, 0, 0, 0, 0);
        add(0, 1, 4'h9, 0, 0, 0, 0);
        add(0, 1, 4'hA, 0, 0, 0, 0);
        add(0, 1, 4'h3, 0, 0, 0, 0);
        add(0, 1, 4'h7, 0, 0, 0, 0);
        add(0, 1, 4'hF, 0, 0, 0, 0);
        add(0, 1, 4'hE, 0, 0, 0, 0);
        add(0, 1, 4'hC, 0, 1, 0, 0);   // locked after C

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_a = vecs[i].rst; bus_a.in_valid = vecs[i].vld;
            bus_a.in_data = vecs[i].data; bus_a.clear_err = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("v%0d locked", i), 32'(bus_a.locked), 32'(vecs[i].lk));
            check($sformatf("v%0d err_pulse", i), 32'(bus_a.err_pulse), 32'(vecs[i].pl));
            check($sformatf("v%0d err_count", i), 32'(bus_a.err_count), 32'(vecs[i].cnt));
        end

        // saturation and clear on the 2-bit counter instance
        step_b(1, 0, 4'h0, 0);
        step_b(0, 1, 4'hE, 0);
        step_b(0, 1, 4'hC, 0);
        step_b(0, 1, 4'h9, 0);
        step_b(0, 1, 4'h3, 0);
        step_b(0, 1, 4'h7, 0);
        check("sat lock", 32'(bus_b.locked), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step_b(0, 1, 4'hA, 0);
            check($sformatf("sat cnt%0d", k), 32'(bus_b.err_count), (k < 3) ? 32'(k) : 32'd3);
            check($sformatf("sat pulse%0d", k), 32'(bus_b.err_pulse), 32'd1);
        end
        check("sat still locked", 32'(bus_b.locked), 32'd1);
        step_b(0, 1, 4'hA, 1);
        check("clr+err cnt", 32'(bus_b.err_count), 32'd0);
        check("clr+err pulse", 32'(bus_b.err_pulse), 32'd1);

        // zero word handling
        step_b(1, 0, 4'h0, 0);
        step_b(0, 1, 4'hE, 0);
        step_b(0, 1, 4'hC, 0);
        step_b(0, 1, 4'h0, 0);
`ifdef PRBS4_CHK_ZERO_DET_EN
        check("zd set", 32'(bus_b.zero_det), 32'd1);
        step_b(0, 1, 4'h9, 0);   // reseeds only
        step_b(0, 1, 4'h3, 0);
        step_b(0, 1, 4'h7, 0);
        step_b(0, 1, 4'hF, 0);
        check("zd run cleared", 32'(bus_b.locked), 32'd0);
        step_b(0, 1, 4'hE, 0);
        check("zd relock", 32'(bus_b.locked), 32'd1);
        check("zd sticky", 32'(bus_b.zero_det), 32'd1);
        step_b(1, 0, 4'h0, 0);
        check("zd rst", 32'(bus_b.zero_det), 32'd0);
`else
        check("zd tied", 32'(bus_b.zero_det), 32'd0);
        check("zd hunt", 32'(bus_b.locked), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/prbs4_checker.md
# prbs4_checker

Receive-side checker for the 4-bit PRBS stream generated by the team's LFSR, with next word = {w[2:0], w[1]^w[3]}. It sits directly downstream of the generator and consumes one 4-bit parallel word per valid cycle. It hunts for sequence alignment, then declares lock and counts word errors against a free-running local replica. On persistent mismatch it drops lock and re-hunts. Used as the loopback/BIST monitor for links driven by the generator.

## Interface
- LOCK_CNT, 4: consecutive predicted-correct words required to lock (≥1)
- LOSS_CNT, 3: consecutive mismatching words in lock that force re-hunt (≥1)
- ERR_W, 16: width of error counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_data carries a sequence word this cycle
- in_data  in  4  PRBS word
- clear_err  in  1  synchronous clear of err_count
- locked  out  1  checker aligned to sequence
- err_pulse  out  1  one-cycle strobe per mismatching word while locked
- err_count  out  ERR_W  saturating count of mismatching words while locked
- zero_det  out  1  sticky all-zero word flag (see Configuration)

## Operation
- f(w) = {w[2:0], w[1]^w[3]}. Valid sequence (period 6): E→C→9→3→7→F→E.
- Words with in_valid=0 are ignored entirely; all state holds.
- State HUNT (reset state):
  - prev register plus prev_ok flag; first valid word after entry only seeds prev (prev_ok←1).
  - Subsequent valid word: if in_data==f(prev), run++; else run←0. prev←in_data always.
  - When run would reach LOCK_CNT: go to LOCKED, exp←f(in_data), miss←0.
  - No errors counted in HUNT.
- State LOCKED:
  - Each valid word: compare in_data to exp; exp←f(exp) regardless of outcome (free-running replica, so a single corrupted word yields exactly one error).
  - Match: miss←0.
  - Mismatch: err_pulse, err_count+1 (saturates at all-ones), miss++.
  - miss reaching LOSS_CNT: go to HUNT, run←0, prev←in_data, prev_ok←1; the error of that word is still counted.
- clear_err: err_count←0; wins over a concurrent increment (err_pulse still fires). Does not affect state or lock.
- Internal counters sized to hold LOCK_CNT / LOSS_CNT; no wrap.

## Timing
- All outputs registered. Reset values: locked=0, err_pulse=0, err_count=0, zero_det=0; state=HUNT, prev_ok=0, run=0, miss=0.
- locked rises the cycle after the valid word completing the LOCK_CNT-th consecutive match; minimum LOCK_CNT+1 valid words from HUNT entry.
- err_pulse high exactly the cycle after the mismatching word is sampled; err_count updates the same cycle.
- locked falls the cycle after the LOSS_CNT-th consecutive mismatching word is sampled.
- rst mid-lock: next cycle all state and outputs at reset values, error count lost.
- Back-to-back valid words at full rate supported; no backpressure.

## Configuration
- PRBS4_CHK_ZERO_DET_EN defined: a valid word 4'h0 in any state sets zero_det (sticky until rst or clear_err). In HUNT a zero word also resets run←0 and prev_ok←0 (generator lockup value, never a seed). In LOCKED it is treated as a normal mismatch.
- Undefined: zero_det tied 0; 4'h0 handled as any other word.

## Test plan
- Lock: rst, then valid E,C,9,3,7 consecutive (LOCK_CNT=4) -> locked=1 the cycle after 7 sampled; err_count=0.
- Single error: locked, send F,E,C then corrupt 9 to 8, then 3,7 -> one err_pulse, err_count=1, locked stays 1.
- Loss: locked, three consecutive mismatching words (LOSS_CNT=3) -> err_count=3, locked=0 after third; resuming correct sequence relocks after LOCK_CNT further matches.
- Gaps/hunt reset: E,C, idle 5 cycles, 9, then A, then 3,7,F,E,C -> no lock until run rebuilds; locked after C.
- Saturation/clear: ERR_W=2, force 5 errors in lock (LOSS_CNT large) -> err_count holds 3; clear_err with concurrent error -> err_count=0, err_pulse=1.
- With PRBS4_CHK_ZERO_DET_EN: word 0 in HUNT -> zero_det=1, run cleared; rst -> zero_det=0.
